// File: rtl/mpu_pkg.sv
// Shared constants, reset values and FSM state type for the MPU-6050 I2C target model.
package mpu_pkg;

  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_WHO_AM_I     = 8'h75;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;

  localparam logic [7:0] PWR_MGMT_1_RST   = 8'h40;
  localparam logic [7:0] REG_DEFAULT_RST  = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } i2c_state_t;

  function automatic logic [7:0] reg_reset_val(input logic [7:0] addr,
                                               input logic [7:0] who_am_i);
    logic [7:0] val;
    val = REG_DEFAULT_RST;
    if (addr == REG_PWR_MGMT_1) val = PWR_MGMT_1_RST;
    if (addr == REG_WHO_AM_I)   val = who_am_i;
    return val;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and decodes SCL edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_d;
  logic       sda_d;

  // Idle bus is high, so reset to '1 to avoid phantom edges after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign sda_s    = sda_sync[1];
  assign scl_rise =  scl_sync[1] & ~scl_d;
  assign scl_fall = ~scl_sync[1] &  scl_d;
  assign start    =  scl_sync[1] &  scl_d &  sda_d & ~sda_sync[1];
  assign stop     =  scl_sync[1] &  scl_d & ~sda_d &  sda_sync[1];

endmodule

// File: rtl/mpu_i2c_target.sv
// MPU-6050 style I2C target: address match, auto-incrementing register pointer,
// byte register file with a host load port.
module mpu_i2c_target
  import mpu_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR     = 7'h68,
  parameter int unsigned REG_DEPTH    = 128,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h68
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       host_we,
  input  logic [6:0] host_addr,
  input  logic [7:0] host_data,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int unsigned PTR_W = $clog2(REG_DEPTH);
  localparam logic [PTR_W-1:0] WHO_PTR = PTR_W'(REG_WHO_AM_I);

  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  i2c_bus_sync u_bus_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (bus_start),
    .stop     (bus_stop)
  );

  i2c_state_t       state, state_nx;
  logic [7:0]       shreg;
  logic [3:0]       bit_cnt;
  logic             rw;
  logic             acked;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       regs [REG_DEPTH];

  logic [7:0]       rx_byte;
  logic [7:0]       rd_byte;
  logic [PTR_W-1:0] host_ptr;
  logic rx_phase, rx_shift, byte_done, addr_hit;
  logic wr_fire, ptr_load, tx_load, tx_shift, rack_ack, sda_oe_nx;

  assign rx_byte  = {shreg[6:0], sda_s};
  assign rd_byte  = regs[ptr];
  assign host_ptr = PTR_W'(host_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // bit_cnt reaches 8 on the 8th SCL rise; the following fall enters the ACK slot.
  always_comb begin
    state_nx = state;
    if (bus_stop) begin
      state_nx = ST_IDLE;
    end else if (bus_start) begin
      state_nx = ST_ADDR;
    end else begin
      unique case (state)
        ST_IDLE:      state_nx = ST_IDLE;
        ST_ADDR: begin
          if (byte_done && !addr_hit)            state_nx = ST_IDLE;
          else if (scl_fall && bit_cnt == 4'd8)  state_nx = ST_ADDR_ACK;
        end
        ST_ADDR_ACK:  if (scl_fall) state_nx = rw ? ST_RDATA : ST_PTR;
        ST_PTR:       if (scl_fall && bit_cnt == 4'd8) state_nx = ST_PTR_ACK;
        ST_PTR_ACK:   if (scl_fall) state_nx = ST_WDATA;
        ST_WDATA:     if (scl_fall && bit_cnt == 4'd8) state_nx = ST_WDATA_ACK;
        ST_WDATA_ACK: if (scl_fall) state_nx = ST_WDATA;
        ST_RDATA:     if (scl_fall && bit_cnt == 4'd8) state_nx = ST_RACK;
        ST_RACK:      if (scl_fall) state_nx = acked ? ST_RDATA : ST_IDLE;
        default:      state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_phase  = (state == ST_ADDR) || (state == ST_PTR) || (state == ST_WDATA);
    rx_shift  = rx_phase && scl_rise && (bit_cnt < 4'd8);
    byte_done = rx_shift && (bit_cnt == 4'd7);
    addr_hit  = (rx_byte[7:1] == DEV_ADDR);
    wr_fire   = byte_done && (state == ST_WDATA);
    ptr_load  = byte_done && (state == ST_PTR);
    rack_ack  = (state == ST_RACK) && scl_rise && !sda_s;
    tx_load   = scl_fall && (((state == ST_ADDR_ACK) && rw) ||
                             ((state == ST_RACK) && acked));
    tx_shift  = scl_fall && (state == ST_RDATA) && (bit_cnt < 4'd8);

    // SDA drive follows the state being entered at each SCL fall.
    sda_oe_nx = sda_oe;
    if (bus_start || bus_stop) begin
      sda_oe_nx = 1'b0;
    end else if (scl_fall) begin
      unique case (state_nx)
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_oe_nx = 1'b1;
        ST_RDATA: sda_oe_nx = tx_load ? ~rd_byte[7] : ~shreg[6];
        default:  sda_oe_nx = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      rw        <= 1'b0;
      acked     <= 1'b0;
      ptr       <= '0;
    end else begin
      sda_oe    <= sda_oe_nx;
      wr_strobe <= wr_fire;

      if (bus_start || (state_nx != state))
        bit_cnt <= '0;
      else if (scl_rise && (rx_phase || state == ST_RDATA) && bit_cnt < 4'd8)
        bit_cnt <= bit_cnt + 4'd1;

      if (rx_shift)      shreg <= rx_byte;
      else if (tx_load)  shreg <= rd_byte;
      else if (tx_shift) shreg <= {shreg[6:0], 1'b0};

      if (byte_done && state == ST_ADDR) rw <= rx_byte[0];
      if (state == ST_RACK && scl_rise)  acked <= ~sda_s;

      // Read pointer advances on the initiator's ACK so the reload at the next fall sees it.
      if (ptr_load)                  ptr <= rx_byte[PTR_W-1:0];
      else if (wr_fire || rack_ack)  ptr <= ptr + 1'b1;

      if (wr_fire) begin
        wr_addr <= 7'(ptr);
        wr_data <= rx_byte;
      end

      if (bus_stop)
        busy <= 1'b0;
      else if (state == ST_ADDR && state_nx == ST_ADDR_ACK)
        busy <= 1'b1;
    end
  end

  // Host write is issued last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++)
        regs[i] <= reg_reset_val(8'(i), WHO_AM_I_VAL);
    end else begin
      if (wr_fire && ptr != WHO_PTR)
        regs[ptr] <= rx_byte;
      if (host_we && host_ptr != WHO_PTR)
        regs[host_ptr] <= host_data;
    end
  end

endmodule

// File: tb/tb_mpu_i2c_target.sv
// Randomised initiator-side bench for mpu_i2c_target with a transaction-level register model.
module tb_mpu_i2c_target;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  logic       host_we = 1'b0;
  logic [6:0] host_addr = '0;
  logic [7:0] host_data = '0;
  logic       sda_oe, wr_strobe, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       sda_i;

  assign sda_i = ~(sda_low | sda_oe);

  always #10 clk = ~clk;

  mpu_i2c_target #(
    .DEV_ADDR     (7'h68),
    .REG_DEPTH    (128),
    .WHO_AM_I_VAL (8'h68)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_data (host_data),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_regs [128];
  logic [6:0]  m_ptr;
  logic        m_busy;
  logic [14:0] wr_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  rd_q [$];
  logic        oe_chk = 1'b0;
  logic        exp_oe = 1'b0;
  logic        quiet  = 1'b0;

  always @(negedge clk) begin : cmp
    logic [14:0] e;
    if (rst_n && oe_chk) begin
      checks++;
      if (sda_oe !== exp_oe) begin
        errors++;
        $display("FAIL sda_oe t=%0t: got %b want %b", $time, sda_oe, exp_oe);
      end
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL busy t=%0t: got %b want %b", $time, busy, m_busy);
      end
    end
    if (rst_n && quiet) begin
      checks++;
      if (sda_oe !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL quiet_frame t=%0t: got oe=%b busy=%b want 0 0", $time, sda_oe, busy);
      end
    end
    if (rst_n && wr_strobe) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_strobe t=%0t: got strobe addr=%h data=%h want none", $time, wr_addr, wr_data);
      end else begin
        e = wr_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL wr_strobe t=%0t: got %h/%h want %h/%h", $time, wr_addr, wr_data, e[14:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #1800000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
    m_regs[7'h6B] = 8'h40;
    m_regs[7'h75] = 8'h68;
    m_ptr  = '0;
    m_busy = 1'b0;
    wr_q.delete();
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_data = d;
    tick(1);
    host_we = 1'b0;
    if (a != 7'h75) m_regs[a] = d;
  endtask

  task automatic clk_bit(input logic drv_low, input logic chk_en, input logic e, output logic got);
    tick(2);
    sda_low = drv_low;
    tick(HALF - 2);
    scl = 1'b1;
    tick(1);
    exp_oe = e;
    oe_chk = chk_en;
    tick(HALF - 2);
    got = sda_i;
    oe_chk = 1'b0;
    tick(1);
    scl = 1'b0;
  endtask

  task automatic start_c();
    tick(2);
    sda_low = 1'b0;
    tick(HALF);
    scl = 1'b1;
    tick(HALF);
    sda_low = 1'b1;
    tick(HALF);
    scl = 1'b0;
  endtask

  task automatic stop_c();
    tick(2);
    sda_low = 1'b1;
    tick(HALF);
    scl = 1'b1;
    tick(HALF);
    sda_low = 1'b0;
    tick(HALF);
    m_busy = 1'b0;
    tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input logic set_busy);
    logic g;
    for (int i = 7; i >= 0; i--) clk_bit(~b[i], 1'b1, 1'b0, g);
    if (set_busy) m_busy = 1'b1;
    clk_bit(1'b0, 1'b1, exp_ack, g);
  endtask

  task automatic recv_byte(input logic [7:0] e, input logic ack, output logic [7:0] got);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b0, 1'b1, ~e[i], g);
      got[i] = g;
    end
    clk_bit(ack, 1'b1, 1'b0, g);
    chk("rd_byte_model", got, e);
  endtask

  // First queued byte is the register pointer, the rest are data bytes.
  task automatic i2c_write(input logic [6:0] a, input int n, input logic do_stop);
    logic hit;
    logic [7:0] b;
    hit = (a == 7'h68);
    start_c();
    send_byte({a, 1'b0}, hit, hit);
    for (int k = 0; k < n; k++) begin
      b = tx_q.pop_front();
      if (hit) begin
        if (k == 0) begin
          m_ptr = b[6:0];
        end else begin
          wr_q.push_back({m_ptr, b});
          if (m_ptr != 7'h75) m_regs[m_ptr] = b;
          m_ptr = m_ptr + 7'd1;
        end
      end
      send_byte(b, hit, 1'b0);
    end
    if (do_stop) stop_c();
    chk("wr_queue_drained", wr_q.size(), 0);
  endtask

  task automatic i2c_read(input logic [6:0] a, input int n);
    logic hit;
    logic [7:0] got;
    hit = (a == 7'h68);
    start_c();
    send_byte({a, 1'b1}, hit, hit);
    if (hit) begin
      for (int k = 0; k < n; k++) begin
        recv_byte(m_regs[m_ptr], (k < n - 1), got);
        rd_q.push_back(got);
        if (k < n - 1) m_ptr = m_ptr + 7'd1;
      end
    end
    stop_c();
  endtask

  task automatic read_at(input logic [6:0] p, input int n);
    tx_q.push_back({1'b0, p});
    i2c_write(7'h68, 1, 1'b0);
    rd_q.delete();
    i2c_read(7'h68, n);
  endtask

  initial begin : main
    logic g;
    model_reset();
    tick(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;
    tick(5);

    read_at(7'h6B, 1);
    chk("pwr_mgmt_reset_val", rd_q[0], 8'h40);

    tx_q.push_back(8'h6B); tx_q.push_back(8'h00);
    i2c_write(7'h68, 2, 1'b1);
    chk("wr_addr_last", wr_addr, 7'h6B);
    chk("wr_data_last", wr_data, 8'h00);
    chk("busy_after_stop", busy, 0);
    read_at(7'h6B, 1);
    chk("pwr_mgmt_written", rd_q[0], 8'h00);

    host_wr(7'h75, 8'h55);
    tx_q.push_back(8'h75); tx_q.push_back(8'h55);
    i2c_write(7'h68, 2, 1'b1);
    read_at(7'h75, 1);
    chk("who_am_i", rd_q[0], 8'h68);

    for (int k = 0; k < 14; k++) host_wr(7'(59 + k), 8'(16 + k));
    read_at(7'h3B, 14);
    for (int k = 0; k < 14; k++) chk("burst_byte", rd_q[k], 8'(16 + k));

    quiet = 1'b1;
    tx_q.push_back(8'h6B); tx_q.push_back(8'h12);
    i2c_write(7'h69, 2, 1'b1);
    quiet = 1'b0;
    read_at(7'h6B, 1);
    chk("miss_no_write", rd_q[0], 8'h00);

    tx_q.push_back(8'h7F); tx_q.push_back(8'hAA); tx_q.push_back(8'hBB);
    i2c_write(7'h68, 3, 1'b1);
    read_at(7'h7F, 2);
    chk("wrap_7f", rd_q[0], 8'hAA);
    chk("wrap_00", rd_q[1], 8'hBB);

    start_c();
    send_byte(8'hD0, 1'b1, 1'b1);
    send_byte(8'h20, 1'b1, 1'b0);
    m_ptr = 7'h20;
    clk_bit(1'b0, 1'b1, 1'b0, g);
    clk_bit(1'b1, 1'b1, 1'b0, g);
    clk_bit(1'b0, 1'b1, 1'b0, g);
    clk_bit(1'b1, 1'b1, 1'b0, g);
    stop_c();
    chk("partial_sda_oe", sda_oe, 0);
    chk("partial_busy", busy, 0);
    read_at(7'h20, 1);
    chk("partial_discarded", rd_q[0], 8'h00);

    host_wr(7'h50, 8'h3C);
    tx_q.push_back(8'h50);
    i2c_write(7'h68, 1, 1'b0);
    start_c();
    send_byte(8'hD1, 1'b1, 1'b1);
    clk_bit(1'b0, 1'b1, 1'b1, g);
    tick(5);
    chk("oe_driving_bit6", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("oe_async_release", sda_oe, 0);
    scl = 1'b1;
    sda_low = 1'b0;
    model_reset();
    tick(4);
    rst_n = 1'b1;
    tick(4);
    chk("post_rst_busy", busy, 0);
    read_at(7'h6B, 1);
    chk("post_rst_pwr_mgmt", rd_q[0], 8'h40);

    for (int it = 0; it < 24; it++) begin
      int unsigned op;
      int unsigned n;
      logic [6:0] a;
      logic [6:0] p;
      op = $urandom_range(0, 3);
      n  = $urandom_range(1, 4);
      a  = ($urandom_range(0, 7) == 0) ? 7'h69 : 7'h68;
      p  = 7'($urandom);
      if ($urandom_range(0, 5) == 0) p = 7'h75;
      if ($urandom_range(0, 5) == 0) p = 7'h7E;
      case (op)
        0: host_wr(p, 8'($urandom));
        1: begin
          tx_q.push_back({1'($urandom), p});
          for (int unsigned k = 1; k < n; k++) tx_q.push_back(8'($urandom));
          i2c_write(a, int'(n), 1'b1);
        end
        2: begin
          read_at(p, int'(n));
        end
        default: i2c_read(a, int'(n));
      endcase
    end

    tick(10);
    chk("final_wr_queue", wr_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpu_i2c_target.md
# mpu_i2c_target

I2C target (responder) that models the MPU-6050 side of the bus driven by the `mpu` initiator. It decodes START/STOP, matches a 7-bit device address, and runs a register pointer with auto-increment over a byte register file. It ACKs writes and serves reads from that file. It is synthesizable: it serves as the in-fabric sensor stand-in for the `mpu` bench and for loop-back bring-up, with a host port that loads "sensor" registers.

## Interface
- `DEV_ADDR`, 7'h68, 7-bit target address matched after START.
- `REG_DEPTH`, 128, register file depth; pointer is log2(REG_DEPTH) bits.
- `WHO_AM_I_VAL`, 8'h68, read-only value at address 8'h75.
- `clk`  in  1  system clock, 50 MHz; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `scl`  in  1  bus clock from the initiator, asynchronous to `clk`.
- `sda_i`  in  1  bus data as seen on the wire.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release. Top level ties `sda = sda_oe ? 1'b0 : 1'bz`.
- `host_we`  in  1  host write strobe into the register file.
- `host_addr`  in  7  host write address.
- `host_data`  in  8  host write data.
- `wr_strobe`  out  1  one-cycle pulse per data byte written over I2C.
- `wr_addr`  out  7  register address of that byte; valid with `wr_strobe`.
- `wr_data`  out  8  data of that byte; valid with `wr_strobe`.
- `busy`  out  1  high from a matched address until STOP.

## Operation
- `scl` and `sda_i` each pass through a 2-flop synchronizer, then an edge register.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while SCL is high.
- START is accepted in any state, which covers repeated START. It clears the bit counter and enters ADDR.
- STOP in any state returns to IDLE, releases `sda_oe` and clears `busy`. A partial byte is discarded.
- SDA is sampled on the synced SCL rise. `sda_oe` changes only on the synced SCL fall.
- Data is MSB first, 8 bits, then a 9th ACK bit.
- States:
  - IDLE: `sda_oe`=0; waits for START.
  - ADDR: shifts in 8 bits.
    - Address ≠ `DEV_ADDR` → IDLE, no ACK, bus ignored until the next START.
    - Match → ADDR_ACK, with the R/W bit latched.
  - ADDR_ACK: drives low for the 9th clock.
    - W → PTR.
    - R → RDATA, loading the shift register from `regs[ptr]`.
  - PTR: shifts in 8 bits; `ptr <= byte[6:0]`, bit 7 ignored. → PTR_ACK (ACK) → WDATA.
  - WDATA: shifts in 8 bits; → WDATA_ACK, which ACKs and pulses `wr_strobe`.
    - Writes `regs[ptr]` unless ptr = 8'h75.
    - Then `ptr <= ptr+1` mod `REG_DEPTH`.
    - Returns to WDATA.
  - RDATA: drives `sda_oe = ~bit` for 8 bits; → RACK, which releases SDA and samples the initiator's ACK.
    - ACK (0): `ptr <= ptr+1` mod `REG_DEPTH`, reload, → RDATA.
    - NACK (1): → IDLE and waits for STOP/START.
- Register reset values: all 8'h00 except 8'h6B = 8'h40 and 8'h75 = `WHO_AM_I_VAL`.
- Host writes update `regs` at any time. A host write to 8'h75 is ignored.
- Host write and I2C write to the same address in the same cycle: host wins, and `wr_strobe` still pulses.
- A read byte is latched into the shift register at load, so host updates never tear a byte in flight.

## Timing
- Reset values: `sda_oe`=0, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, ptr=0, state IDLE.
- `rst_n` low mid-transfer releases SDA asynchronously.
- Edge-detect latency: 3 `clk` cycles from a pin edge. `sda_oe` changes 3 cycles after the SCL pin falls, which gives hold time ≥ 60 ns at 50 MHz.
- The design requires SCL low and high phases ≥ 8 `clk` cycles (≤ 3 MHz SCL); standard/fast mode from `mpu` satisfies this.
- `wr_strobe` fires in the cycle after the 8th data bit is sampled, before the ACK clock.
- `busy` rises on the address-ACK SCL fall and falls the cycle after STOP is detected.

## Structure
- `mpu_pkg` holds:
  - register address constants (`REG_PWR_MGMT_1` = 8'h6B, `REG_WHO_AM_I` = 8'h75, `REG_ACCEL_XOUT_H` = 8'h3B);
  - reset values;
  - the state enum.
- Sub-module `i2c_bus_sync` contains the synchronizers, SCL rise/fall pulses, and START/STOP pulses. It is shared later with other bus monitors.
- The FSM, shifter, pointer and register file live in the top module.

## Test plan
- Write 0x68|W, ptr 0x6B, data 0x00 → three ACKs; `wr_strobe` with `wr_addr`=0x6B, `wr_data`=0x00; read-back of 0x6B = 0x00.
- Write ptr 0x75, repeated START, 0x68|R, then NACK → byte 0x68 on SDA; a prior write of 0x55 to 0x75 leaves it 0x68.
- Host loads 0x3B..0x48 with 0x10..0x1D, then a 14-byte burst read from 0x3B, ACK ×13 and NACK on the last → bytes 0x10..0x1D in order.
- Address 0x69 → no ACK, `sda_oe` stays 0 for the whole frame, `busy` stays 0.
- Write ptr 0x7F, then data 0xAA, 0xBB → 0x7F = 0xAA, 0x00 = 0xBB (pointer wraps).
- STOP after 4 data bits, and separately `rst_n` pulsed mid-read → state IDLE, `sda_oe`=0, register unchanged; the next transaction succeeds.
